// File: rtl/ram_word_writer_if.sv
// Write port between ram_word_writer and the CPU data RAM.
// The writer holds wr_req, wr_addr and wr_data steady until the RAM returns wr_ack.
interface ram_word_writer_if;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/ram_word_writer.sv
// Button/switch driven word writer: two debounced presses build one 32-bit word,
// which is then written to the next word address. `WRITER_CKSUM_EN adds a running sum of committed words.
module ram_word_writer #(
    parameter int DB_CYCLES = 100000,
    parameter int ADDR_LAST = 60
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    btn_raw,
    input  logic [15:0]             sw,
    ram_word_writer_if.master       bus,
    output logic                    hold,
    output logic                    done,
    output logic [31:0]             cksum
);
    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [31:0]    LAST    = 32'(ADDR_LAST);

    typedef enum logic [1:0] {S_LO, S_HI, S_REQ, S_DONE} state_t;

    logic [1:0]    sync_q;
    logic          btn_s;
    logic [CW-1:0] db_cnt;
    logic          db_lvl, db_lvl_q, press;

    assign btn_s = sync_q[1];

    // The level flips on the same edge the counter would reach DB_CYCLES.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q   <= '0;
            db_cnt   <= '0;
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            db_lvl_q <= db_lvl;
            if (btn_s == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_lvl <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_lvl & ~db_lvl_q;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        accept;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_LO;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        accept  = 1'b0;
        case (state_q)
            S_LO: if (press) begin
                data_d[15:0] = sw;
                state_d      = S_HI;
            end
            S_HI: if (press) begin
                data_d[31:16] = sw;
                req_d         = 1'b1;
                state_d       = S_REQ;
            end
            // Presses here are dropped; only the ack moves us on.
            S_REQ: if (req_q && bus.wr_ack) begin
                accept = 1'b1;
                req_d  = 1'b0;
                if (addr_q == LAST) begin
                    addr_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = S_LO;
                end
            end
            S_DONE: if (press) begin
                done_d  = 1'b0;
                state_d = S_LO;
            end
            default: state_d = S_LO;
        endcase
    end

    assign bus.wr_req  = req_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign hold        = (state_q == S_HI) || (state_q == S_REQ);
    assign done        = done_q;

`ifdef WRITER_CKSUM_EN
    logic [31:0] cksum_q;
    always_ff @(posedge clk or posedge clr) begin
        if (clr)         cksum_q <= '0;
        else if (accept) cksum_q <= cksum_q + data_q;
    end
    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif
endmodule

// File: doc/ram_word_writer.md
Name: ram_word_writer

Overview:
- Operator-driven memory writer: a push button and 16 switches enter 32-bit words, which are written to sequential word addresses in CPU data RAM over a req/ack write port.
- It is the write-side counterpart of the top-level RAM display scan, which reads words 0..60 in steps of 4; this block fills the same window.
- Sits beside MIPS_CPU at top level and asserts a CPU hold while a word is being entered or written.

Parameters:
DB_CYCLES, 100000, clocks the synchronised button must stay stable before the debounced level changes (1 ms at 100 MHz).
ADDR_LAST, 60, byte address of the last word in the fill window; must be a multiple of 4.

Ports:
clk  input  1  system clock, one clock domain
clr  input  1  reset, asynchronous, active-high
btn_raw  input  1  raw, bouncing push-button level
sw  input  16  switch data half-word
wr_req  output  1  write request to RAM port
wr_addr  output  32  byte address of the current word
wr_data  output  32  word to write
wr_ack  input  1  RAM accepted the write; sampled only while wr_req=1
hold  output  1  CPU stall request
done  output  1  fill window completed
cksum  output  32  running sum of committed words (see Optional Feature)

Behaviour:
- Reset (async on clr=1): state S_LO; wr_req=0, wr_addr=0, wr_data=0, hold=0, done=0, cksum=0; synchroniser, debounce counter and debounced level all 0.
- Button path:
  - 2-FF synchroniser on btn_raw.
  - Counter counts while the synced value differs from the debounced level and clears whenever they match.
  - When the counter reaches DB_CYCLES, the debounced level takes the synced value and the counter clears.
  - press = 1-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
- FSM (state changes on the clock edge where press is seen):
  - S_LO: on press, wr_data[15:0]<=sw -> S_HI.
  - S_HI: on press, wr_data[31:16]<=sw, wr_req<=1 -> S_REQ.
  - S_REQ: wr_req, wr_addr and wr_data are held stable. On an edge with wr_ack=1:
    - wr_req<=0.
    - If wr_addr==ADDR_LAST: wr_addr<=0, done<=1 -> S_DONE.
    - Otherwise: wr_addr<=wr_addr+4 -> S_LO.
    - Presses in S_REQ are dropped.
  - S_DONE: on press, done<=0 -> S_LO; sw is not captured on this press.
- hold = 1 in S_HI and S_REQ (registered with the state), else 0.
- wr_ack while wr_req=0 is ignored. The earliest ack is accepted on the first edge where wr_req is already 1, so a minimum write takes 1 cycle of req.
- Latency from a clean btn_raw rise to the capture edge is 2 sync cycles + DB_CYCLES + 1.
- wr_addr arithmetic is 32-bit. wr_addr[1:0] is always 0. The address never exceeds ADDR_LAST.
- clr mid-write drops wr_req immediately. No partial word is retained.

Optional Feature:
- Macro: WRITER_CKSUM_EN.
- Defined: on each accepted ack, cksum<=cksum+wr_data (mod 2^32). cksum is cleared only by clr, not by leaving S_DONE.
- Undefined: no adder is built and cksum is constant 0.

Test Plan:
All scenarios use DB_CYCLES=4, ADDR_LAST=8.
1. Bounce: btn_raw toggles every 2 clk for 30 clk, then holds 0 -> no press; state stays S_LO, hold=0, wr_data=0.
2. Clean press with sw=0x1234, release, clean press with sw=0xABCD -> wr_req=1, wr_addr=0x0, wr_data=0xABCD1234, hold=1.
3. From scenario 2, hold wr_ack=0 for 5 clk, then pulse it -> wr_req and wr_data stay stable for 5 clk; the edge after the ack gives wr_req=0, wr_addr=0x4, hold=0. wr_ack held at 1 in S_LO has no effect.
4. Write three words -> the third ack (at addr 8) gives done=1, wr_addr=0. Next press -> done=0, S_LO, wr_data unchanged.
5. Assert clr for 1 clk while wr_req=1 at addr 4 -> wr_req, wr_addr, hold, done and cksum are all 0 before the next clk edge.
6. With WRITER_CKSUM_EN, commit 0xFFFFFFFF then 0x00000002 -> cksum=0x00000001. Without the macro, cksum=0 throughout.
